// File: rtl/aftab_ir_fetch.sv
// AFTAB instruction fetch / IR stage: fetches one word at pc and latches it,
// exposing IR fields and immediate-format selects (selects decoded only with AFTAB_IMM_SEL_DECODE_EN).
module aftab_ir_fetch #(
  parameter int size    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startFetch,
  input  logic            flush,
  input  logic [size-1:0] pc,
  input  logic            memReady,
  input  logic [size-1:0] memDataIn,
  output logic            memRead,
  output logic [size-1:0] memAddr,
  output logic            irValid,
  output logic            fetchBusy,
  output logic            misalignErr,
  output logic            timeoutErr,
  output logic            IR7,
  output logic            IR20,
  output logic            IR31,
  output logic [3:0]      IR11_8,
  output logic [7:0]      IR19_12,
  output logic [3:0]      IR24_21,
  output logic [5:0]      IR30_25,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            selI,
  output logic            selS,
  output logic            selBUJ,
  output logic            selIJ,
  output logic            selSB,
  output logic            selU,
  output logic            selISBJ,
  output logic            selIS,
  output logic            selB,
  output logic            selJ,
  output logic            selISB,
  output logic            selUJ,
  output logic            illegalOp
);

  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

  localparam logic [7:0]      TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [size-1:0] NOP_INSTR   = 32'h0000_0013;

  state_t          state;
  logic [7:0]      wait_cnt;
  logic [size-1:0] ir;
  logic            accept;

  // A word is captured only when memory answers in WAIT and no flush overrides it.
  assign accept = (state == WAIT) && memReady && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      ir          <= NOP_INSTR;
      memRead     <= 1'b0;
      memAddr     <= '0;
      irValid     <= 1'b0;
      fetchBusy   <= 1'b0;
      misalignErr <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      misalignErr <= 1'b0;
      timeoutErr  <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        memRead   <= 1'b0;
        fetchBusy <= 1'b0;
        irValid   <= 1'b0;
      end else begin
        case (state)
          IDLE, VALID: begin
            if (startFetch) begin
              irValid <= 1'b0;
              if (pc[1:0] == 2'b00) begin
                state     <= WAIT;
                memRead   <= 1'b1;
                fetchBusy <= 1'b1;
                memAddr   <= pc;
                wait_cnt  <= 8'd0;
              end else begin
                state       <= IDLE;
                misalignErr <= 1'b1;
              end
            end
          end
          WAIT: begin
            if (memReady) begin
              ir        <= memDataIn;
              state     <= VALID;
              memRead   <= 1'b0;
              fetchBusy <= 1'b0;
              irValid   <= 1'b1;
            end else if (wait_cnt + 8'd1 == TIMEOUT_CNT) begin
              // memRead has now been high for exactly TIMEOUT cycles
              timeoutErr <= 1'b1;
              state      <= IDLE;
              memRead    <= 1'b0;
              fetchBusy  <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          default: begin
            state     <= IDLE;
            memRead   <= 1'b0;
            fetchBusy <= 1'b0;
            irValid   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign opcode  = ir[6:0];
  assign rd      = ir[11:7];
  assign funct3  = ir[14:12];
  assign rs1     = ir[19:15];
  assign rs2     = ir[24:20];
  assign funct7  = ir[31:25];
  assign IR7     = ir[7];
  assign IR11_8  = ir[11:8];
  assign IR19_12 = ir[19:12];
  assign IR20    = ir[20];
  assign IR24_21 = ir[24:21];
  assign IR30_25 = ir[30:25];
  assign IR31    = ir[31];

`ifdef AFTAB_IMM_SEL_DECODE_EN
  // Bit order: {illegal, UJ, ISB, IS, ISBJ, SB, IJ, BUJ, J, B, U, S, I}
  function automatic logic [12:0] sel_decode(input logic [6:0] op);
    logic f_i, f_s, f_b, f_u, f_j, f_r;
    f_i = 1'b0; f_s = 1'b0; f_b = 1'b0; f_u = 1'b0; f_j = 1'b0; f_r = 1'b0;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: f_i = 1'b1;
      7'b0100011:                                     f_s = 1'b1;
      7'b1100011:                                     f_b = 1'b1;
      7'b0110111, 7'b0010111:                         f_u = 1'b1;
      7'b1101111:                                     f_j = 1'b1;
      7'b0110011:                                     f_r = 1'b1;
      default: ;
    endcase
    return {~(f_i | f_s | f_b | f_u | f_j | f_r),
            f_u | f_j,
            f_i | f_s | f_b,
            f_i | f_s,
            f_i | f_s | f_b | f_j,
            f_s | f_b,
            f_i | f_j,
            f_b | f_u | f_j,
            f_j, f_b, f_u, f_s, f_i};
  endfunction

  logic [12:0] sel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= sel_decode(NOP_INSTR[6:0]);
    end else if (accept) begin
      sel_q <= sel_decode(memDataIn[6:0]);
    end
  end

  assign selI      = sel_q[0];
  assign selS      = sel_q[1];
  assign selU      = sel_q[2];
  assign selB      = sel_q[3];
  assign selJ      = sel_q[4];
  assign selBUJ    = sel_q[5];
  assign selIJ     = sel_q[6];
  assign selSB     = sel_q[7];
  assign selISBJ   = sel_q[8];
  assign selIS     = sel_q[9];
  assign selISB    = sel_q[10];
  assign selUJ     = sel_q[11];
  assign illegalOp = sel_q[12];
`else
  // The controller drives immediate selects itself in this build.
  logic unused_accept;
  assign unused_accept = accept;
  assign selI      = 1'b0;
  assign selS      = 1'b0;
  assign selU      = 1'b0;
  assign selB      = 1'b0;
  assign selJ      = 1'b0;
  assign selBUJ    = 1'b0;
  assign selIJ     = 1'b0;
  assign selSB     = 1'b0;
  assign selISBJ   = 1'b0;
  assign selIS     = 1'b0;
  assign selISB    = 1'b0;
  assign selUJ     = 1'b0;
  assign illegalOp = 1'b0;
`endif

endmodule

// File: tb/tb_aftab_ir_fetch.sv
// Directed plus randomized bench for aftab_ir_fetch, checked against a transaction-level model.
module tb_aftab_ir_fetch;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        startFetch = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;
  logic        memReady = 1'b0;
  logic [31:0] memDataIn = '0;
  logic        memRead, irValid, fetchBusy, misalignErr, timeoutErr;
  logic [31:0] memAddr;
  logic        IR7, IR20, IR31;
  logic [3:0]  IR11_8, IR24_21;
  logic [7:0]  IR19_12;
  logic [5:0]  IR30_25;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic selI, selS, selBUJ, selIJ, selSB, selU, selISBJ, selIS, selB, selJ, selISB, selUJ, illegalOp;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model_ir;

  aftab_ir_fetch #(.size(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .startFetch(startFetch), .flush(flush), .pc(pc),
    .memReady(memReady), .memDataIn(memDataIn), .memRead(memRead), .memAddr(memAddr),
    .irValid(irValid), .fetchBusy(fetchBusy), .misalignErr(misalignErr), .timeoutErr(timeoutErr),
    .IR7(IR7), .IR20(IR20), .IR31(IR31), .IR11_8(IR11_8), .IR19_12(IR19_12),
    .IR24_21(IR24_21), .IR30_25(IR30_25), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .selI(selI), .selS(selS), .selBUJ(selBUJ),
    .selIJ(selIJ), .selSB(selSB), .selU(selU), .selISBJ(selISBJ), .selIS(selIS),
    .selB(selB), .selJ(selJ), .selISB(selISB), .selUJ(selUJ), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  logic [31:0] ir_fields, ir_decode;
  logic [12:0] sel_obs;
  assign ir_fields = {IR31, IR30_25, IR24_21, IR20, IR19_12, IR11_8, IR7, opcode};
  assign ir_decode = {funct7, rs2, rs1, funct3, rd, opcode};
  assign sel_obs   = {selI, selS, selB, selU, selJ, selBUJ, selIJ, selSB,
                      selISBJ, selIS, selISB, selUJ, illegalOp};

  // Format sets and their unions, straight from the opcode table.
  function automatic logic [12:0] exp_sel(input logic [6:0] op);
`ifdef AFTAB_IMM_SEL_DECODE_EN
    bit i, s, b, u, j, r;
    i = op inside {7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011};
    s = (op == 7'b0100011);
    b = (op == 7'b1100011);
    u = op inside {7'b0110111, 7'b0010111};
    j = (op == 7'b1101111);
    r = (op == 7'b0110011);
    return {i, s, b, u, j, b | u | j, i | j, s | b, i | s | b | j, i | s, i | s | b, u | j,
            !(i | s | b | u | j | r)};
`else
    return (op == 7'b1111111) ? 13'd0 : 13'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ir(input string tag);
    check({tag, "_fields"}, ir_fields, model_ir);
    check({tag, "_decode"}, ir_decode, model_ir);
    check({tag, "_sel"}, 32'(sel_obs), 32'(exp_sel(model_ir[6:0])));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // delay = WAIT cycle in which memReady is raised; beyond TO means no answer.
  task automatic do_fetch(input logic [31:0] a, input logic [31:0] word, input int delay);
    startFetch = 1'b1;
    pc = a;
    tick();
    startFetch = 1'b0;
    pc = $urandom();
    if (a[1:0] != 2'b00) begin
      check("misalign_pulse", 32'({misalignErr, memRead, fetchBusy, irValid}), 32'h8);
      tick();
      check("misalign_once", 32'({misalignErr, memRead}), 32'h0);
      check_ir("misalign_ir");
      return;
    end
    check("fetch_start", 32'({memRead, fetchBusy, irValid}), 32'h6);
    check("fetch_addr", memAddr, a);
    for (int i = 1; i <= TO; i++) begin
      memDataIn = $urandom();
      if (i == delay) begin
        memReady = 1'b1;
        memDataIn = word;
      end
      tick();
      memReady = 1'b0;
      if (i == delay) begin
        model_ir = word;
        check("fetch_done", 32'({irValid, memRead, fetchBusy, timeoutErr}), 32'h8);
        check_ir("fetch");
        return;
      end
      if (i == TO) begin
        check("timeout_pulse", 32'({timeoutErr, memRead, fetchBusy, irValid}), 32'h8);
        check_ir("timeout_ir");
        tick();
        check("timeout_once", 32'({timeoutErr, memRead}), 32'h0);
        return;
      end
      check("wait_hold", 32'({memRead, timeoutErr, irValid}), 32'h4);
    end
  endtask

  logic [6:0] op_pool [0:11] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011, 7'b0100011,
                                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011,
                                  7'b0001111, 7'b1111111};

  initial begin
    logic [31:0] w;
    model_ir = 32'h0000_0013;

    // Reset
    tick();
    tick();
    check("rst_ctrl", 32'({memRead, irValid, fetchBusy, misalignErr, timeoutErr}), 32'h0);
    check("rst_addr", memAddr, 32'h0);
    check_ir("rst");
    rst = 1'b1;
    tick();

    // Basic fetch, answer on third WAIT cycle
    do_fetch(32'h100, 32'h00A00093, 3);
    check("rd_field", 32'(rd), 32'h1);
    check("ir24_21", 32'(IR24_21), 32'h5);

    // memReady in VALID ignored, IR held
    memReady = 1'b1;
    memDataIn = 32'hDEAD_BEEF;
    tick();
    memReady = 1'b0;
    check("valid_hold", 32'({irValid, memRead}), 32'h2);
    check_ir("valid_hold");

    // Misaligned from VALID: irValid drops, no memory access
    do_fetch(32'h102, 32'h0, 1);
    check("misalign_valid", 32'({irValid, memRead}), 32'h0);
    tick();
    check("misalign_idle", 32'({memRead, fetchBusy}), 32'h0);

    // Timeout
    do_fetch(32'h200, 32'h0, TO + 5);
    check("timeout_irvalid", 32'(irValid), 32'h0);

    // flush beats memReady in WAIT
    startFetch = 1'b1;
    pc = 32'h300;
    tick();
    startFetch = 1'b0;
    tick();
    flush = 1'b1;
    memReady = 1'b1;
    memDataIn = 32'hFE000EE3;
    tick();
    flush = 1'b0;
    check("flush_ctrl", 32'({irValid, memRead, fetchBusy}), 32'h0);
    check_ir("flush");
    tick();
    memReady = 1'b0;
    check("flush_idle_ready", 32'({irValid, memRead}), 32'h0);
    check_ir("flush_idle");

    // B-format, then illegal opcode
    do_fetch(32'h400, 32'hFE000EE3, 1);
    do_fetch(32'h404, 32'h0000007F, 2);

    // flush beats startFetch in VALID
    startFetch = 1'b1;
    flush = 1'b1;
    pc = 32'h500;
    tick();
    startFetch = 1'b0;
    flush = 1'b0;
    check("flush_start", 32'({irValid, memRead, fetchBusy}), 32'h0);
    tick();
    check("flush_start_idle", 32'(memRead), 32'h0);

    // startFetch during WAIT is ignored
    startFetch = 1'b1;
    pc = 32'h600;
    tick();
    pc = 32'h700;
    tick();
    startFetch = 1'b0;
    check("wait_ignore_addr", memAddr, 32'h600);
    check("wait_ignore_read", 32'(memRead), 32'h1);
    memReady = 1'b1;
    memDataIn = 32'h0000_1037;
    tick();
    memReady = 1'b0;
    model_ir = 32'h0000_1037;
    check("wait_ignore_done", 32'(irValid), 32'h1);
    check_ir("wait_ignore");

    // Randomized fetches
    for (int n = 0; n < 40; n++) begin
      w = $urandom();
      w[6:0] = op_pool[$urandom_range(0, 11)];
      if ($urandom_range(0, 3) == 0)
        do_fetch($urandom() | 32'h1, w, 1);
      else
        do_fetch($urandom() & 32'hFFFF_FFFC, w, $urandom_range(1, TO + 2));
    end

    // Asynchronous reset in WAIT
    startFetch = 1'b1;
    pc = 32'h800;
    tick();
    startFetch = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    model_ir = 32'h0000_0013;
    check("async_rst_ctrl", 32'({memRead, fetchBusy, irValid}), 32'h0);
    check("async_rst_addr", memAddr, 32'h0);
    check_ir("async_rst");
    tick();
    rst = 1'b1;
    memReady = 1'b1;
    memDataIn = 32'h1234_5067;
    tick();
    memReady = 1'b0;
    check("post_rst_ready", 32'({irValid, memRead}), 32'h0);
    check_ir("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
